// File: rtl/tone_meas_pkg.sv
// Shared types and defaults for the tone measurement block.
package tone_meas_pkg;

    // Measurement FSM: waiting for the first rising crossing, or timing a cycle.
    typedef enum logic {
        S_IDLE,
        S_MEAS
    } state_e;

    // Hysteresis half-width around zero; crossings must clear this band.
    localparam int DEF_HYST   = 1024;

    // Default period counter width.
    localparam int DEF_CWIDTH = 16;

    // Saturation value of the period counter at the default width.
    localparam int CNT_MAX    = (1 << DEF_CWIDTH) - 1;

endpackage

// File: rtl/tone_meas_zc_detect.sv
// Hysteresis zero-crossing detector: tracks signal polarity and flags
// the accepted sample that first pushes the signal above +HYST.
module zc_detect
    import tone_meas_pkg::*;
#(
    parameter int OWIDTH = 32,
    parameter int HYST   = DEF_HYST
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_clear,
    input  logic                     i_acc,
    input  logic signed [OWIDTH-1:0] i_data,
    output logic                     o_pol,
    output logic                     o_rise
);

    localparam logic signed [OWIDTH-1:0] HYST_POS = OWIDTH'(HYST);
    localparam logic signed [OWIDTH-1:0] HYST_NEG = -HYST_POS;

    logic aboveBand;
    logic belowBand;
    logic pol_q;
    logic pol_d;

    // Signed compares against the band edges; samples inside the band change nothing.
    always_comb begin
        aboveBand = (i_data > HYST_POS);
        belowBand = (i_data < HYST_NEG);
    end

    // Next polarity: only accepted samples outside the band move it; clear forces low.
    always_comb begin
        pol_d = pol_q;
        if (i_clear) begin
            pol_d = 1'b0;
        end else if (i_acc) begin
            if (aboveBand) begin
                pol_d = 1'b1;
            end else if (belowBand) begin
                pol_d = 1'b0;
            end
        end
    end

    // Polarity register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pol_q <= 1'b0;
        end else begin
            pol_q <= pol_d;
        end
    end

    // A rising event is an accepted sample that lifts a low polarity over +HYST.
    always_comb begin
        o_pol  = pol_q;
        o_rise = i_acc && !pol_q && aboveBand;
    end

endmodule

// File: rtl/tone_meas.sv
// Tone measurement sink: times each full signal cycle between rising
// crossings (in accepted samples) and reports its period, max and min.
module tone_meas
    import tone_meas_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int OWIDTH = 2 * DWIDTH,
    parameter int CWIDTH = DEF_CWIDTH,
    parameter int HYST   = DEF_HYST
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_clear,
    input  logic signed [OWIDTH-1:0] i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic        [CWIDTH-1:0] o_period,
    output logic signed [OWIDTH-1:0] o_max,
    output logic signed [OWIDTH-1:0] o_min,
    output logic                     o_ovf,
    output logic                     o_valid,
    input  logic                     i_ready
);

    localparam logic [CWIDTH-1:0] CNT_SAT = {CWIDTH{1'b1}};
    localparam logic [CWIDTH-1:0] CNT_ONE = CWIDTH'(1);

    state_e                   state_q,     state_d;
    logic        [CWIDTH-1:0] cnt_q,       cnt_d;
    logic signed [OWIDTH-1:0] runMax_q,    runMax_d;
    logic signed [OWIDTH-1:0] runMin_q,    runMin_d;
    logic                     runOvf_q,    runOvf_d;
    logic        [CWIDTH-1:0] resPeriod_q, resPeriod_d;
    logic signed [OWIDTH-1:0] resMax_q,    resMax_d;
    logic signed [OWIDTH-1:0] resMin_q,    resMin_d;
    logic                     resOvf_q,    resOvf_d;
    logic                     resValid_q,  resValid_d;

    logic acc;
    logic rise;
    logic pol;

    // Input is stalled only while a result is waiting on a busy consumer.
    always_comb begin
        o_ready = !resValid_q || i_ready;
        acc     = i_valid && o_ready;
    end

    zc_detect #(
        .OWIDTH (OWIDTH),
        .HYST   (HYST)
    ) u_zc (
        .clk     (clk),
        .rstn    (rstn),
        .i_clear (i_clear),
        .i_acc   (acc),
        .i_data  (i_data),
        .o_pol   (pol),
        .o_rise  (rise)
    );

    // Next-state logic: FSM, running statistics and the result hand-off.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        runMax_d    = runMax_q;
        runMin_d    = runMin_q;
        runOvf_d    = runOvf_q;
        resPeriod_d = resPeriod_q;
        resMax_d    = resMax_q;
        resMin_d    = resMin_q;
        resOvf_d    = resOvf_q;
        resValid_d  = resValid_q;

        if (resValid_q && i_ready) begin
            resValid_d = 1'b0;
        end

        if (i_clear) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            resValid_d = 1'b0;
        end else if (acc) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_d  = S_MEAS;
                        cnt_d    = CNT_ONE;
                        runMax_d = i_data;
                        runMin_d = i_data;
                        runOvf_d = 1'b0;
                    end
                end
                S_MEAS: begin
                    if (rise) begin
                        resPeriod_d = cnt_q;
                        resMax_d    = runMax_q;
                        resMin_d    = runMin_q;
                        resOvf_d    = runOvf_q;
                        resValid_d  = 1'b1;
                        cnt_d       = CNT_ONE;
                        runMax_d    = i_data;
                        runMin_d    = i_data;
                        runOvf_d    = 1'b0;
                    end else begin
                        if (cnt_q == CNT_SAT) begin
                            runOvf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        if (i_data > runMax_q) begin
                            runMax_d = i_data;
                        end
                        if (i_data < runMin_q) begin
                            runMin_d = i_data;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            runMax_q    <= '0;
            runMin_q    <= '0;
            runOvf_q    <= 1'b0;
            resPeriod_q <= '0;
            resMax_q    <= '0;
            resMin_q    <= '0;
            resOvf_q    <= 1'b0;
            resValid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            runMax_q    <= runMax_d;
            runMin_q    <= runMin_d;
            runOvf_q    <= runOvf_d;
            resPeriod_q <= resPeriod_d;
            resMax_q    <= resMax_d;
            resMin_q    <= resMin_d;
            resOvf_q    <= resOvf_d;
            resValid_q  <= resValid_d;
        end
    end

    // Result outputs come straight from their registers.
    always_comb begin
        o_period = resPeriod_q;
        o_max    = resMax_q;
        o_min    = resMin_q;
        o_ovf    = resOvf_q;
        o_valid  = resValid_q;
    end

endmodule

// File: tb/tb_tone_meas.sv
// Testbench for tone_meas: directed stepped-sine and edge-case streams,
// with expected results queued at stimulus time and checked by a monitor.
module tb_tone_meas;

    localparam int DWIDTH = 16;
    localparam int OWIDTH = 32;
    localparam int CWIDTH = 16;

    typedef struct {
        longint period;
        longint maxV;
        longint minV;
        longint ovf;
    } result_t;

    logic                     clk;
    logic                     rstn;
    logic                     i_clear;
    logic signed [OWIDTH-1:0] i_data;
    logic                     i_valid;
    logic                     o_ready;
    logic        [CWIDTH-1:0] o_period;
    logic signed [OWIDTH-1:0] o_max;
    logic signed [OWIDTH-1:0] o_min;
    logic                     o_ovf;
    logic                     o_valid;
    logic                     i_ready;

    int testsRun  = 0;
    int failCount = 0;
    int cycleCount = 0;

    result_t expQ[$];
    int      stampQ[$];

    // Stepped sine levels, already sign-extended from 16 bits.
    int sineLevels[8] = '{0, 23166, 32767, 23166, 0, -23166, -32768, -23166};

    tone_meas #(
        .DWIDTH (DWIDTH),
        .OWIDTH (OWIDTH),
        .CWIDTH (CWIDTH),
        .HYST   (1024)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_clear  (i_clear),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_period (o_period),
        .o_max    (o_max),
        .o_min    (o_min),
        .o_ovf    (o_ovf),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle count used to timestamp accepted results.
    always @(posedge clk) begin
        cycleCount <= cycleCount + 1;
    end

    // Hard stop in case some stimulus loop never returns.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: a result handshake completes on the coming edge; pop and compare.
    always @(negedge clk) begin
        if (rstn && o_valid && i_ready) begin
            if (expQ.size() == 0) begin
                testsRun++;
                failCount++;
                $display("[TB] FAIL unexpected_result: got period %0d, expected no result", o_period);
            end else begin
                result_t exp;
                exp = expQ.pop_front();
                stampQ.push_back(cycleCount);
                checkOutput("period", longint'(o_period), exp.period);
                checkOutput("max", longint'(o_max), exp.maxV);
                checkOutput("min", longint'(o_min), exp.minV);
                checkOutput("ovf", longint'(o_ovf), exp.ovf);
            end
        end
    end

    task automatic pushExpected(input longint period, input longint maxV, input longint minV,
                                input longint ovf);
        result_t r;
        r.period = period;
        r.maxV   = maxV;
        r.minV   = minV;
        r.ovf    = ovf;
        expQ.push_back(r);
    endtask

    // Offer one sample and wait (bounded) until it is accepted.
    task automatic applyStimulus(input int value, input bit gap);
        int waitCycles = 0;
        i_data  = OWIDTH'(value);
        i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready && waitCycles < 1000) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!o_ready) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL accept_timeout: got o_ready %0d, expected 1", o_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveSine(input int nSamples, input bit gap);
        for (int s = 0; s < nSamples; s++) begin
            applyStimulus(sineLevels[(s / 5) % 8], gap);
        end
    endtask

    task automatic applyReset();
        rstn    = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for all queued results, then allow stray ones to show up.
    task automatic waitDrain(input string name);
        int w = 0;
        while (expQ.size() != 0 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (10) @(posedge clk);
        #1;
        checkOutput(name, longint'(expQ.size()), 0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"}, longint'(o_valid), 0);
        checkOutput({tag, "_period"}, longint'(o_period), 0);
        checkOutput({tag, "_max"}, longint'(o_max), 0);
        checkOutput({tag, "_min"}, longint'(o_min), 0);
        checkOutput({tag, "_ovf"}, longint'(o_ovf), 0);
        checkOutput({tag, "_ready"}, longint'(o_ready), 1);
    endtask

    initial begin
        rstn    = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;

        // Reset state.
        #1;
        checkReset("reset");
        applyReset();

        // Plain stepped sine: three full cycles of 40 samples.
        stampQ.delete();
        repeat (3) pushExpected(40, 32767, -32768, 0);
        driveSine(160, 1'b0);
        waitDrain("drain_sine");
        checkOutput("spacing_sine", stampQ.size() >= 2 ? longint'(stampQ[1] - stampQ[0]) : -1, 40);

        // Same stream with i_valid toggling; results identical, spacing doubled.
        applyReset();
        stampQ.delete();
        repeat (3) pushExpected(40, 32767, -32768, 0);
        driveSine(160, 1'b1);
        waitDrain("drain_toggle");
        checkOutput("spacing_toggle", stampQ.size() >= 2 ? longint'(stampQ[1] - stampQ[0]) : -1, 80);

        // Backpressure: hold the first result for 100 cycles.
        applyReset();
        repeat (3) pushExpected(40, 32767, -32768, 0);
        fork
            driveSine(160, 1'b0);
            begin
                int w = 0;
                while (!o_valid && w < 2000) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                checkOutput("bp_seen", longint'(o_valid), 1);
                i_ready = 1'b0;
                repeat (100) begin
                    @(negedge clk);
                    checkOutput("bp_valid", longint'(o_valid), 1);
                    checkOutput("bp_ready", longint'(o_ready), 0);
                    checkOutput("bp_period", longint'(o_period), 40);
                    checkOutput("bp_max", longint'(o_max), 32767);
                end
                @(posedge clk);
                #1;
                i_ready = 1'b1;
            end
        join
        waitDrain("drain_bp");

        // Noise inside the hysteresis band, then the sine.
        applyReset();
        for (int s = 0; s < 200; s++) begin
            applyStimulus((s % 2 == 0) ? 512 : -512, 1'b0);
        end
        repeat (5) @(posedge clk);
        #1;
        checkOutput("noise_no_result", longint'(o_valid), 0);
        repeat (3) pushExpected(40, 32767, -32768, 0);
        driveSine(160, 1'b0);
        waitDrain("drain_noise");

        // Period counter saturation.
        applyReset();
        pushExpected(65535, 2000, -2000, 1);
        applyStimulus(-2000, 1'b0);
        for (int s = 0; s < 70000; s++) begin
            applyStimulus(2000, 1'b0);
        end
        applyStimulus(-2000, 1'b0);
        applyStimulus(2000, 1'b0);
        waitDrain("drain_ovf");

        // Reset mid-cycle: pending measurement is lost, outputs return to zero.
        applyReset();
        pushExpected(40, 32767, -32768, 0);
        driveSine(60, 1'b0);
        waitDrain("drain_pre_rst");
        rstn = 1'b0;
        #1;
        checkReset("midrst");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) pushExpected(40, 32767, -32768, 0);
        driveSine(160, 1'b0);
        waitDrain("drain_post_rst");

        // Synchronous clear mid-cycle: measurement dropped, result registers held.
        applyReset();
        pushExpected(40, 32767, -32768, 0);
        driveSine(60, 1'b0);
        waitDrain("drain_pre_clr");
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        checkOutput("clr_valid", longint'(o_valid), 0);
        checkOutput("clr_period_held", longint'(o_period), 40);
        checkOutput("clr_min_held", longint'(o_min), -32768);
        repeat (3) pushExpected(40, 32767, -32768, 0);
        driveSine(160, 1'b0);
        waitDrain("drain_post_clr");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
